arith_result_stage: RTL

ARITH_RESULT_STAGE -- requirements
Module: arith_result_stage

---
 rtl/arith_result_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/arith_result_stage.sv
// ---------------------------------------------------------------------------
// arith_result_stage
//
// Two-entry result FIFO placed behind the arithmetic unit. Each entry holds
// the result word and its CO/OVF/N/Z flags. The stage also keeps sticky
// overflow/carry flags and a count of accepted entries.
//
// Build option:
//   ARITH_RESULT_SATURATE_EN -- when defined, an entry that arrives with
//   OVF set is stored as the saturated result instead of the wrapped one.
//   The saturated value is the largest positive number when CO=0, and the
//   most negative number when CO=1. N follows CO and Z is forced to 0.
//   CO and OVF are stored as they arrived.
//
// Parameters:
//   W   data width of the result word
//   CW  width of the accepted-operation counter
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   in_valid/in_ready  upstream handshake. in_ready comes from a register.
//   res_in, *_in       result and flags from the arithmetic unit
//   out_valid/out_ready downstream handshake on the head entry
//   res_out, *_out     head entry. These read 0 while out_valid=0.
//   sticky_ovf/co      OR of OVF/CO over all accepted entries
//   clr_sticky         synchronous clear of the sticky flags and op_cnt
//   op_cnt             accepted entries, modulo 2^CW
// ---------------------------------------------------------------------------
module arith_result_stage #(
   parameter int W  = 8,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  res_in,
   input  logic          co_in,
   input  logic          ovf_in,
   input  logic          n_in,
   input  logic          z_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  res_out,
   output logic          co_out,
   output logic          ovf_out,
   output logic          n_out,
   output logic          z_out,
   output logic          sticky_ovf,
   output logic          sticky_co,
   input  logic          clr_sticky,
   output logic [CW-1:0] op_cnt
);

   typedef struct packed {
      logic [W-1:0] res;
      logic         co;
      logic         ovf;
      logic         n;
      logic         z;
   } entry_t;

   entry_t          mem_q [2];
   entry_t          wr_entry;
   entry_t          head;
   logic            rd_ptr_q;
   logic            wr_ptr_q;
   logic [1:0]      occ_q;
   logic [1:0]      occ_d;
   logic            in_ready_q;
   logic            out_valid_q;
   logic            sticky_ovf_q;
   logic            sticky_co_q;
   logic [CW-1:0]   op_cnt_q;
   logic            push;
   logic            pop;

   // The handshake outputs come straight from flops. This keeps out_ready
   // from reaching in_ready through any combinational path.
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;

   assign push = in_valid  & in_ready_q;
   assign pop  = out_valid_q & out_ready;

   // Form the entry that will be written on a push.
   always_comb begin
      wr_entry.res = res_in;
      wr_entry.co  = co_in;
      wr_entry.ovf = ovf_in;
      wr_entry.n   = n_in;
      wr_entry.z   = z_in;
`ifdef ARITH_RESULT_SATURATE_EN
      // Here CO acts as the sign of the true result. CO=0 means positive
      // overflow, so store the largest positive value. CO=1 means negative
      // overflow, so store the most negative value.
      if (ovf_in) begin
         wr_entry.res = co_in ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
         wr_entry.n   = co_in;
         wr_entry.z   = 1'b0;
      end
`endif
   end

   // NOTE: the entry storage has no reset. The handshake and the output
   // masking depend only on occupancy. After a reset the stale contents
   // cannot be seen, so a reset on this wide datapath would add nothing.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   // Next occupancy. A push and a pop in the same cycle cancel out.
   always_comb begin
      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments. All flops
   // therefore sample the values from before the clock edge, and their
   // order in the code does not matter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q       <= 2'd0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         occ_q       <= occ_d;
         in_ready_q  <= (occ_d != 2'd2);
         out_valid_q <= (occ_d != 2'd0);
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // Sticky flags and counter. A clear that lands in the same cycle as a
   // push starts the new period with that entry already counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_ovf_q <= 1'b0;
         sticky_co_q  <= 1'b0;
         op_cnt_q     <= '0;
      end else if (clr_sticky) begin
         sticky_ovf_q <= push & ovf_in;
         sticky_co_q  <= push & co_in;
         op_cnt_q     <= push ? CW'(1) : '0;
      end else if (push) begin
         sticky_ovf_q <= sticky_ovf_q | ovf_in;
         sticky_co_q  <= sticky_co_q  | co_in;
         op_cnt_q     <= op_cnt_q + CW'(1);
      end
   end

   // The head entry reads as all zeros while the FIFO is empty.
   always_comb begin
      head = '0;
      if (out_valid_q) head = mem_q[rd_ptr_q];
   end

   assign res_out    = head.res;
   assign co_out     = head.co;
   assign ovf_out    = head.ovf;
   assign n_out      = head.n;
   assign z_out      = head.z;
   assign sticky_ovf = sticky_ovf_q;
   assign sticky_co  = sticky_co_q;
   assign op_cnt     = op_cnt_q;

endmodule
